// File: rtl/decode_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// decode_ctrl_pipe : registered RV32I(+M) control decoder with 2-entry skid
// Revision 1.0
// ============================================================================
module decode_ctrl_pipe #(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   input  logic            ex_mem_read,
   input  logic [4:0]      ex_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [2:0]      out_encoding,
   output logic            out_reg_write,
   output logic            out_alu_src,
   output logic            out_mem_read,
   output logic            out_mem_write,
   output logic            out_mem_to_reg,
   output logic            out_is_branch,
   output logic [4:0]      out_alu_op,
   output logic            out_is_muldiv,
   output logic            out_illegal
);

   localparam logic [6:0] c_OP_R      = 7'b0110011;
   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_IMM    = 7'b0010011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

   localparam logic [6:0] c_F7_BASE   = 7'b0000000;
   localparam logic [6:0] c_F7_ALT    = 7'b0100000;
   localparam logic [6:0] c_F7_MULDIV = 7'b0000001;

   localparam logic [2:0] c_ENC_R = 3'd0;
   localparam logic [2:0] c_ENC_I = 3'd1;
   localparam logic [2:0] c_ENC_S = 3'd2;
   localparam logic [2:0] c_ENC_B = 3'd3;
   localparam logic [2:0] c_ENC_U = 3'd4;
   localparam logic [2:0] c_ENC_J = 3'd5;

   localparam logic [4:0] c_ALU_ADD  = 5'd0;
   localparam logic [4:0] c_ALU_SUB  = 5'd1;
   localparam logic [4:0] c_ALU_AND  = 5'd2;
   localparam logic [4:0] c_ALU_OR   = 5'd3;
   localparam logic [4:0] c_ALU_XOR  = 5'd4;
   localparam logic [4:0] c_ALU_SLL  = 5'd5;
   localparam logic [4:0] c_ALU_SRL  = 5'd6;
   localparam logic [4:0] c_ALU_SRA  = 5'd7;
   localparam logic [4:0] c_ALU_SLT  = 5'd8;
   localparam logic [4:0] c_ALU_SLTU = 5'd9;
   localparam logic [4:0] c_ALU_PASS = 5'd10;
   localparam logic [4:0] c_ALU_MUL  = 5'd11;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [2:0]      enc;
      logic            reg_write;
      logic            alu_src;
      logic            mem_read;
      logic            mem_write;
      logic            mem_to_reg;
      logic            is_branch;
      logic [4:0]      alu_op;
      logic            is_muldiv;
      logic            illegal;
   } entry_t;

   // funct3 -> ALU op shared by OP and OP-IMM; alt selects SUB/SRA
   function automatic logic [4:0] f_alu_base(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  f_alu_base = alt ? c_ALU_SUB : c_ALU_ADD;
         3'b001:  f_alu_base = c_ALU_SLL;
         3'b010:  f_alu_base = c_ALU_SLT;
         3'b011:  f_alu_base = c_ALU_SLTU;
         3'b100:  f_alu_base = c_ALU_XOR;
         3'b101:  f_alu_base = alt ? c_ALU_SRA : c_ALU_SRL;
         3'b110:  f_alu_base = c_ALU_OR;
         default: f_alu_base = c_ALU_AND;
      endcase
   endfunction

   logic [6:0] w_opcode;
   logic [2:0] w_f3;
   logic [6:0] w_f7;
   logic       w_bad;
   entry_t     w_dec;

   assign w_opcode = in_instr[6:0];
   assign w_f3     = in_instr[14:12];
   assign w_f7     = in_instr[31:25];

   always_comb begin
      w_dec       = '0;
      w_dec.instr = in_instr;
      w_dec.pc    = in_pc;
      w_dec.enc   = c_ENC_I;
      w_bad       = 1'b0;
      case (w_opcode)
         c_OP_R: begin
            w_dec.enc       = c_ENC_R;
            w_dec.reg_write = 1'b1;
            if (w_f7 == c_F7_BASE) begin
               w_dec.alu_op = f_alu_base(w_f3, 1'b0);
            end else if (w_f7 == c_F7_ALT) begin
               w_dec.alu_op = f_alu_base(w_f3, 1'b1);
               w_bad        = (w_f3 != 3'b000) && (w_f3 != 3'b101);
            end else if ((w_f7 == c_F7_MULDIV) && ENABLE_M) begin
               w_dec.alu_op    = c_ALU_MUL + {2'b00, w_f3};
               w_dec.is_muldiv = 1'b1;
            end else begin
               w_bad = 1'b1;
            end
         end
         c_OP_LOAD: begin
            w_dec.alu_src    = 1'b1;
            w_dec.mem_read   = 1'b1;
            w_dec.mem_to_reg = 1'b1;
            w_dec.reg_write  = 1'b1;
            w_bad = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
         end
         c_OP_IMM: begin
            w_dec.alu_src   = 1'b1;
            w_dec.reg_write = 1'b1;
            if (w_f3 == 3'b001) begin
               w_dec.alu_op = c_ALU_SLL;
               w_bad        = (w_f7 != c_F7_BASE);
            end else if (w_f3 == 3'b101) begin
               w_dec.alu_op = f_alu_base(w_f3, w_f7[5]);
               w_bad        = (w_f7 != c_F7_BASE) && (w_f7 != c_F7_ALT);
            end else begin
               w_dec.alu_op = f_alu_base(w_f3, 1'b0);
            end
         end
         c_OP_STORE: begin
            w_dec.enc       = c_ENC_S;
            w_dec.alu_src   = 1'b1;
            w_dec.mem_write = 1'b1;
            w_bad           = (w_f3 > 3'b010);
         end
         c_OP_BRANCH: begin
            w_dec.enc       = c_ENC_B;
            w_dec.is_branch = 1'b1;
            w_dec.alu_op    = c_ALU_SUB;
            w_bad           = (w_f3 == 3'b010) || (w_f3 == 3'b011);
         end
         c_OP_JAL: begin
            w_dec.enc       = c_ENC_J;
            w_dec.reg_write = 1'b1;
            w_dec.is_branch = 1'b1;
         end
         c_OP_JALR: begin
            w_dec.reg_write = 1'b1;
            w_dec.is_branch = 1'b1;
            w_bad           = (w_f3 != 3'b000);
         end
         c_OP_LUI: begin
            w_dec.enc       = c_ENC_U;
            w_dec.alu_src   = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.alu_op    = c_ALU_PASS;
         end
         c_OP_AUIPC: begin
            w_dec.enc       = c_ENC_U;
            w_dec.alu_src   = 1'b1;
            w_dec.reg_write = 1'b1;
         end
         default: w_bad = 1'b1;
      endcase
      // Illegal words still travel down the pipe so execute can raise the trap
      if (w_bad) begin
         w_dec         = '0;
         w_dec.instr   = in_instr;
         w_dec.pc      = in_pc;
         w_dec.enc     = c_ENC_I;
         w_dec.illegal = 1'b1;
      end
   end

   entry_t     r_buf [2];
   logic       r_head;
   logic [1:0] r_count;

   entry_t     w_head;
   logic       w_uses_rs1;
   logic       w_uses_rs2;
   logic       w_hazard;
   logic       w_enq;
   logic       w_deq;
   logic       w_wr_idx;

   assign w_head     = r_buf[r_head];
   assign w_uses_rs1 = (w_head.enc != c_ENC_U) && (w_head.enc != c_ENC_J);
   assign w_uses_rs2 = (w_head.enc == c_ENC_R) || (w_head.enc == c_ENC_S) ||
                       (w_head.enc == c_ENC_B);
   assign w_hazard   = ex_mem_read && (ex_rd != 5'd0) &&
                       ((w_uses_rs1 && (w_head.instr[19:15] == ex_rd)) ||
                        (w_uses_rs2 && (w_head.instr[24:20] == ex_rd)));

   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0) && !w_hazard;
   assign w_enq     = in_valid && in_ready && !flush;
   assign w_deq     = out_valid && out_ready;
   assign w_wr_idx  = r_head ^ r_count[0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_buf[0] <= '0;
         r_buf[1] <= '0;
         r_head   <= 1'b0;
         r_count  <= 2'd0;
      end else if (flush) begin
         r_head  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_enq) begin
            r_buf[w_wr_idx] <= w_dec;
         end
         if (w_deq) begin
            r_head <= ~r_head;
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign out_instr      = w_head.instr;
   assign out_pc         = w_head.pc;
   assign out_encoding   = w_head.enc;
   assign out_reg_write  = w_head.reg_write;
   assign out_alu_src    = w_head.alu_src;
   assign out_mem_read   = w_head.mem_read;
   assign out_mem_write  = w_head.mem_write;
   assign out_mem_to_reg = w_head.mem_to_reg;
   assign out_is_branch  = w_head.is_branch;
   assign out_alu_op     = w_head.alu_op;
   assign out_is_muldiv  = w_head.is_muldiv;
   assign out_illegal    = w_head.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// tb_decode_ctrl_pipe : directed + random bench with queue-based reference
// Revision 1.0
// ============================================================================
module tb_decode_ctrl_pipe;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        ex_mem_read;
   logic [4:0]  ex_rd;
   logic        out_ready;

   logic        in_ready, out_valid;
   logic [31:0] out_instr, out_pc;
   logic [2:0]  out_encoding;
   logic        out_reg_write, out_alu_src, out_mem_read, out_mem_write;
   logic        out_mem_to_reg, out_is_branch, out_is_muldiv, out_illegal;
   logic [4:0]  out_alu_op;

   logic        n_in_ready, n_out_valid;
   logic [31:0] n_out_instr, n_out_pc;
   logic [2:0]  n_out_encoding;
   logic        n_out_reg_write, n_out_alu_src, n_out_mem_read, n_out_mem_write;
   logic        n_out_mem_to_reg, n_out_is_branch, n_out_is_muldiv, n_out_illegal;
   logic [4:0]  n_out_alu_op;

   logic [15:0] ctrl, n_ctrl;
   assign ctrl   = {out_encoding, out_reg_write, out_alu_src, out_mem_read, out_mem_write,
                    out_mem_to_reg, out_is_branch, out_alu_op, out_is_muldiv, out_illegal};
   assign n_ctrl = {n_out_encoding, n_out_reg_write, n_out_alu_src, n_out_mem_read,
                    n_out_mem_write, n_out_mem_to_reg, n_out_is_branch, n_out_alu_op,
                    n_out_is_muldiv, n_out_illegal};

   decode_ctrl_pipe #(.XLEN(32), .ENABLE_M(1'b1)) u_dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_encoding(out_encoding), .out_reg_write(out_reg_write),
      .out_alu_src(out_alu_src), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_mem_to_reg(out_mem_to_reg), .out_is_branch(out_is_branch), .out_alu_op(out_alu_op),
      .out_is_muldiv(out_is_muldiv), .out_illegal(out_illegal));

   decode_ctrl_pipe #(.XLEN(32), .ENABLE_M(1'b0)) u_dut_nom (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(n_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .ex_mem_read(ex_mem_read),
      .ex_rd(ex_rd), .out_valid(n_out_valid), .out_ready(out_ready), .out_instr(n_out_instr),
      .out_pc(n_out_pc), .out_encoding(n_out_encoding), .out_reg_write(n_out_reg_write),
      .out_alu_src(n_out_alu_src), .out_mem_read(n_out_mem_read),
      .out_mem_write(n_out_mem_write), .out_mem_to_reg(n_out_mem_to_reg),
      .out_is_branch(n_out_is_branch), .out_alu_op(n_out_alu_op),
      .out_is_muldiv(n_out_is_muldiv), .out_illegal(n_out_illegal));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int errors;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;
   ent_t mq[$];
   bit   exp_ready;
   bit   exp_valid;

   // Control word layout: {enc[3], rw, alu_src, mem_rd, mem_wr, mem2reg, branch, alu_op[5], muldiv, illegal}
   function automatic logic [15:0] m_decode(input logic [31:0] ins, input bit en_m);
      int op, f3, f7, alu, enc;
      bit ok, rw, as, mr, mw, m2r, br, md;
      int base_ops [8];
      base_ops = '{0, 5, 8, 9, 4, 6, 3, 2};
      op = int'(ins[6:0]);
      f3 = int'(ins[14:12]);
      f7 = int'(ins[31:25]);
      ok = 1; enc = 1; alu = 0;
      rw = 0; as = 0; mr = 0; mw = 0; m2r = 0; br = 0; md = 0;
      case (op)
         'h33: begin
            enc = 0; rw = 1;
            if (f7 == 0) alu = base_ops[f3];
            else if (f7 == 'h20) begin ok = (f3 == 0 || f3 == 5); alu = (f3 == 0) ? 1 : 7; end
            else if (f7 == 1 && en_m) begin alu = 11 + f3; md = 1; end
            else ok = 0;
         end
         'h03: begin as = 1; mr = 1; m2r = 1; rw = 1; ok = !(f3 inside {3, 6, 7}); end
         'h13: begin
            as = 1; rw = 1; alu = base_ops[f3];
            if (f3 == 1) ok = (f7 == 0);
            if (f3 == 5) begin ok = (f7 == 0 || f7 == 'h20); if (f7 == 'h20) alu = 7; end
         end
         'h23: begin enc = 2; as = 1; mw = 1; ok = (f3 <= 2); end
         'h63: begin enc = 3; br = 1; alu = 1; ok = !(f3 inside {2, 3}); end
         'h6F: begin enc = 5; rw = 1; br = 1; end
         'h67: begin enc = 1; rw = 1; br = 1; ok = (f3 == 0); end
         'h37: begin enc = 4; as = 1; rw = 1; alu = 10; end
         'h17: begin enc = 4; as = 1; rw = 1; end
         default: ok = 0;
      endcase
      if (!ok) return {3'd1, 6'b0, 5'd0, 1'b0, 1'b1};
      return {3'(enc), rw, as, mr, mw, m2r, br, 5'(alu), md, 1'b0};
   endfunction

   function automatic bit m_stall(input logic [31:0] ins, input bit mrd, input logic [4:0] rd);
      logic [15:0] c;
      int enc;
      bit r1, r2;
      c   = m_decode(ins, 1'b1);
      enc = int'(c[15:13]);
      r1  = !(enc inside {4, 5});
      r2  = (enc inside {0, 2, 3});
      return mrd && (rd != 0) && ((r1 && ins[19:15] == rd) || (r2 && ins[24:20] == rd));
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops [10];
      logic [6:0] op, f7;
      int idx, k;
      ops = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33};
      idx = $urandom_range(0, 10);
      op  = (idx == 10) ? 7'($urandom()) : ops[idx];
      k   = $urandom_range(0, 3);
      f7  = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : (k == 2) ? 7'h01 : 7'($urandom());
      return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom()),
              5'($urandom()), op};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc);
      in_valid = v;
      in_instr = ins;
      in_pc    = pc;
   endtask

   task automatic settle();
      bit hz;
      #1;
      hz        = (mq.size() > 0) && m_stall(mq[0].instr, ex_mem_read, ex_rd);
      exp_ready = (mq.size() < 2);
      exp_valid = (mq.size() > 0) && !hz;
      check("in_ready", in_ready, exp_ready);
      check("out_valid", out_valid, exp_valid);
      if (mq.size() > 0) begin
         check("head_instr", out_instr, mq[0].instr);
         check("head_pc", out_pc, mq[0].pc);
         check("head_ctrl", ctrl, m_decode(mq[0].instr, 1'b1));
      end
   endtask

   task automatic advance();
      ent_t e;
      if (flush) begin
         mq.delete();
      end else begin
         if (exp_valid && out_ready) void'(mq.pop_front());
         if (in_valid && exp_ready) begin
            e.instr = in_instr;
            e.pc    = in_pc;
            mq.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   task automatic tick();
      settle();
      advance();
   endtask

   localparam logic [31:0] c_ADD  = 32'h002081B3;
   localparam logic [31:0] c_SUB  = 32'h402081B3;
   localparam logic [31:0] c_MUL  = 32'h022081B3;
   localparam logic [31:0] c_ADDI = 32'h00500093;
   localparam logic [31:0] c_LW   = 32'h0000A103;
   localparam logic [31:0] c_SW   = 32'h0020A023;
   localparam logic [31:0] c_ADDI3 = 32'h00700193;

   initial begin
      checks = 0;
      errors = 0;
      reset_n = 1'b1; flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0; out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      #1 reset_n = 1'b0;

      // Reset state
      @(negedge clk); #1;
      check("rst_valid", out_valid, 1'b0);
      check("rst_instr", out_instr, 32'h0);
      check("rst_pc", out_pc, 32'h0);
      check("rst_ctrl", ctrl, 16'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // 1: single ADD, visible next cycle
      drive(1'b1, c_ADD, 32'h100); tick();
      drive(1'b0, 32'h0, 32'h0); out_ready = 1'b1; settle();
      check("t1_valid", out_valid, 1'b1);
      check("t1_ctrl", ctrl, 16'h1000);
      advance();

      // 2: SUB then MUL, both M settings
      drive(1'b1, c_SUB, 32'h104); tick();
      drive(1'b1, c_MUL, 32'h108); settle();
      check("t2_sub", ctrl, 16'h1004);
      advance();
      drive(1'b0, 32'h0, 32'h0); settle();
      check("t2_mul", ctrl, 16'h102E);
      check("t2_nom_valid", n_out_valid, 1'b1);
      check("t2_nom_ready", n_in_ready, 1'b1);
      check("t2_nom_instr", n_out_instr, c_MUL);
      check("t2_nom_pc", n_out_pc, 32'h108);
      check("t2_nom_ctrl", n_ctrl, 16'h2001);
      advance();
      tick();

      // 3: backpressure, third instruction held upstream
      out_ready = 1'b0;
      drive(1'b1, c_ADDI, 32'h200); tick();
      drive(1'b1, c_LW, 32'h204); tick();
      drive(1'b1, c_SW, 32'h208); settle();
      check("t3_full", in_ready, 1'b0);
      advance();
      out_ready = 1'b1; tick();
      settle();
      check("t3_reopen", in_ready, 1'b1);
      advance();
      drive(1'b0, 32'h0, 32'h0); settle();
      check("t3_third", out_instr, c_SW);
      advance();
      tick();

      // 4: load-use stall, enqueue continues behind the stalled head
      ex_mem_read = 1'b1; ex_rd = 5'd1;
      drive(1'b1, c_ADD, 32'h300); tick();
      for (int k = 0; k < 3; k++) begin
         if (k == 1) drive(1'b1, c_ADDI, 32'h304);
         else drive(1'b0, 32'h0, 32'h0);
         settle();
         check("t4_stall", out_valid, 1'b0);
         advance();
      end
      ex_mem_read = 1'b0; settle();
      check("t4_release", out_valid, 1'b1);
      check("t4_head", out_instr, c_ADD);
      advance();
      tick();
      ex_mem_read = 1'b1; ex_rd = 5'd0;
      drive(1'b1, c_ADD, 32'h308); tick();
      drive(1'b0, 32'h0, 32'h0); settle();
      check("t4_rd0", out_valid, 1'b1);
      advance();
      ex_mem_read = 1'b0;
      tick();

      // 5: flush drops buffered entries and the concurrent input
      out_ready = 1'b0;
      drive(1'b1, c_ADD, 32'h500); tick();
      drive(1'b1, c_SUB, 32'h504); tick();
      flush = 1'b1; drive(1'b1, c_ADDI3, 32'h508); tick();
      flush = 1'b0; drive(1'b0, 32'h0, 32'h0); settle();
      check("t5_valid", out_valid, 1'b0);
      check("t5_ready", in_ready, 1'b1);
      advance();
      drive(1'b1, c_ADD, 32'h510); tick();
      flush = 1'b1; drive(1'b1, c_ADDI3, 32'h514); tick();
      flush = 1'b0; drive(1'b1, c_SUB, 32'h518); tick();
      drive(1'b0, 32'h0, 32'h0); out_ready = 1'b1; settle();
      check("t5_head", out_instr, c_SUB);
      advance();
      tick();

      // 6: asynchronous reset mid-cycle, then all-zero word is illegal
      out_ready = 1'b0;
      drive(1'b1, c_ADD, 32'h600); tick();
      drive(1'b0, 32'h0, 32'h0); settle();
      #2 reset_n = 1'b0;
      #1;
      check("t6_async_valid", out_valid, 1'b0);
      check("t6_async_instr", out_instr, 32'h0);
      mq.delete();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      drive(1'b1, 32'h0, 32'h700); tick();
      drive(1'b0, 32'h0, 32'h0); settle();
      check("t6_illegal", ctrl, 16'h2001);
      advance();

      // Random traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, rand_instr(), $urandom());
         out_ready   = ($urandom_range(0, 3) != 0);
         ex_mem_read = 1'($urandom_range(0, 1));
         ex_rd       = 5'($urandom_range(0, 3));
         flush       = ($urandom_range(0, 19) == 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
